multiplier_seq: RTL
===================

Name: multiplier_seq

Overview:
Iterative shift-add multiplier. It is the sequential, parametrised successor of the team's combinational multiplier. It trades one W x W array for a single W+1-bit adder run over W cycles, and adds a start/busy/ready handshake and a per-operation signed/unsigned mode. It sits in the FPU datapath where mantissa products are not timing-critical and area matters, e.g. the low-area significand multiply path.

Parameters:
W, 24, operand width in bits (W >= 2); product width is 2*W.
CW, $clog2(W+1), iteration counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous reset, active low.
start_i  input  1  request a multiply; sampled only when busy_o = 0.
sign_i  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start_i.
Data_A_i  input  W  multiplicand; sampled with start_i.
Data_B_i  input  W  multiplier; sampled with start_i.
busy_o  output  1  operation in progress; start_i ignored while high.
ready_o  output  1  one-cycle pulse: Data_S_o holds a new result.
Data_S_o  output  2*W  product; registered, held until the next result.

Behaviour:
- Clock and reset: single clock clk. rst_n is synchronous and active-low. It is sampled on the rising edge of clk, and it overrides every other input, including a start in the same cycle.
- Reset values: busy_o=0, ready_o=0, Data_S_o=0, state=IDLE, counter=0, internal registers=0.
- FSM states:
  - IDLE: busy_o=0.
  - CALC: busy_o=1.
  - FIN: busy_o=1.
- IDLE -> CALC: on an edge with start_i=1.
  - Latch sign_i.
  - If sign_i=1, replace each operand by its magnitude (|x| fits in W bits unsigned, including -2^(W-1)).
  - Record neg = sign_i & (A[W-1] ^ B[W-1]).
  - Clear the accumulator. Load counter = W.
- CALC, one iteration per cycle:
  - If multiplier LSB = 1, add the multiplicand to the upper W+1 bits of the accumulator.
  - Shift the {carry, accumulator, multiplier} concatenation right by 1.
  - Decrement the counter.
  - When the counter reaches 0 after the W-th iteration, go to FIN.
- FIN, one cycle:
  - Data_S_o <= neg ? two's complement of the 2W-bit accumulator : accumulator.
  - ready_o <= 1. State -> IDLE.
- Latency: if start is accepted at edge t, ready_o=1 and Data_S_o are valid in the cycle after edge t+W+1. busy_o falls at that same edge.
- ready_o is high for exactly one cycle. It is never asserted other than on completion.
- Back-to-back: start_i=1 during the ready_o cycle is accepted (busy_o=0). The throughput limit is one result per W+2 cycles.
- start_i while busy_o=1: ignored. Operand and sign inputs are not re-sampled, and the running operation is unaffected.
- Operand inputs may change freely after acceptance; only the latched copies are used.
- Arithmetic: the result is exact modulo 2^(2W) for all inputs in both modes. No overflow is possible, because the signed range -2^(W-1)*-2^(W-1) = 2^(2W-2) fits in 2W signed bits.
- Zero operand: runs the full W iterations and yields 0; there is no early termination. In signed mode, a negative zero result stays 0.
- Reset mid-operation: abort and return to IDLE with reset values. Data_S_o is cleared, and no ready_o pulse is produced for the aborted operation.
- Data_S_o changes only in FIN or on reset.

Test Plan:
- W=8, unsigned, A=255, B=255, start at edge t: busy_o=1 from edge t to edge t+9; Data_S_o=16'hFE01 and ready_o=1 for one cycle after edge t+9.
- W=8, signed, A=8'h80 (-128), B=8'h80: Data_S_o=16'h4000. Also A=8'hFD (-3), B=8'h05: Data_S_o=16'hFFF1 (-15). The same operands unsigned (253*5) give 16'h04F1.
- W=8: start A=7, B=6, then assert start_i with A=9, B=9 at edge t+3 while busy: result 16'd42 at the expected cycle; the second request is ignored, and ready_o pulses exactly once.
- W=8, back-to-back: assert start_i (A=12, B=11) in the ready_o cycle of a previous op: accepted; 16'd132 appears W+2 cycles later; Data_S_o holds the previous value in between.
- W=8: start A=200, B=3, drive rst_n=0 at edge t+4 for one cycle: busy_o=0, Data_S_o=0, and no ready_o follows. A subsequent start A=0, B=77 yields 0 with the normal latency.
- W=24 random regression, 10k ops, mixed sign_i: Data_S_o matches the 48-bit reference product (signed or unsigned per op), and latency is always 25 cycles.

Source files
------------

// File: rtl/multiplier_seq.sv
// multiplier_seq: iterative shift-add multiplier, W x W -> 2W.
// One accumulate-and-shift step per cycle over W cycles, with a
// start/busy/ready handshake and a per-operation signed/unsigned mode.
// Signed operands are converted to magnitudes on acceptance. The sign
// of the product is applied in the final cycle.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous reset, active low (wins over start_i)
//   start_i  request a multiply, sampled only while busy_o = 0
//   sign_i   1 = two's-complement operands, 0 = unsigned
//   Data_A_i multiplicand (W bits)
//   Data_B_i multiplier (W bits)
//   busy_o   operation in progress
//   ready_o  one-cycle pulse: Data_S_o holds a new result
//   Data_S_o registered 2W-bit product, held until the next result
module multiplier_seq #(
    parameter int W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             sign_i,
    input  logic [W-1:0]     Data_A_i,
    input  logic [W-1:0]     Data_B_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [2*W-1:0]   Data_S_o
);
    localparam int CW = $clog2(W+1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            neg;
    logic [W-1:0]    mcand;
    // {hi, lo} is the 2W-bit accumulator; lo starts out holding the
    // multiplier and is consumed from the bottom as product bits enter.
    logic [W-1:0]    hi, lo;
    logic [W:0]      sum;
    logic [W-1:0]    mag_a, mag_b;
    logic [2*W-1:0]  acc;

    // Magnitude of -2^(W-1) is 2^(W-1), which still fits W bits unsigned.
    assign mag_a = (sign_i & Data_A_i[W-1]) ? -Data_A_i : Data_A_i;
    assign mag_b = (sign_i & Data_B_i[W-1]) ? -Data_B_i : Data_B_i;

    // W+1-bit adder: the carry becomes the top accumulator bit after the shift.
    assign sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    assign acc = {hi, lo};

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = CALC;
            // Counter reaches 0 on this edge: W-th iteration done.
            CALC:    if (cnt == CW'(1)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            neg      <= 1'b0;
            mcand    <= '0;
            hi       <= '0;
            lo       <= '0;
            ready_o  <= 1'b0;
            Data_S_o <= '0;
        end else begin
            ready_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        neg   <= sign_i & (Data_A_i[W-1] ^ Data_B_i[W-1]);
                        mcand <= mag_a;
                        lo    <= mag_b;
                        hi    <= '0;
                        cnt   <= CW'(W);
                    end
                end
                CALC: begin
                    // {carry, hi, lo} >> 1 after the conditional add.
                    {hi, lo} <= {sum, lo[W-1:1]};
                    cnt      <= cnt - CW'(1);
                end
                FIN: begin
                    Data_S_o <= neg ? -acc : acc;
                    ready_o  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
